// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit majority-of-3 vote,
// optional parity, one-cycle data and error strobes.
module uart_rx #(
  parameter int DATA_SIZE = 8,
  parameter int PRESCALE  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX_IN,
  input  logic                 PAR_EN,
  input  logic                 PAR_TYP,
  output logic [DATA_SIZE-1:0] P_DATA,
  output logic                 Data_Valid,
  output logic                 Par_Err,
  output logic                 Stp_Err
);

  localparam int EW = $clog2(PRESCALE);
  localparam int BW = $clog2(DATA_SIZE);

  localparam logic [EW-1:0] E_LAST = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] E_S0   = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] E_S1   = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] E_S2   = EW'(PRESCALE / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DELIVER
  } state_t;

  state_t state, state_nxt;

  logic                 sync1, rx_s, rx_p;
  logic [EW-1:0]        edge_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [1:0]           smp;
  logic [DATA_SIZE-1:0] shreg;
  logic                 par_en_q, par_typ_q, par_fail;
  logic                 start_det, at_s2, at_last, vote;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_p  <= 1'b1;
    end else begin
      sync1 <= RX_IN;
      rx_s  <= sync1;
      rx_p  <= rx_s;
    end
  end

  assign start_det = !rx_s && rx_p;
  assign at_s2     = edge_cnt == E_S2;
  assign at_last   = edge_cnt == E_LAST;
  // third sample is the live line value at E_S2
  assign vote = (smp[0] & smp[1]) |
                (smp[0] & rx_s)   |
                (smp[1] & rx_s);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_det) state_nxt = START;
      START: begin
        if (at_s2 && vote) state_nxt = IDLE;
        else if (at_last)  state_nxt = DATA;
      end
      DATA: begin
        if (at_last && bit_cnt == B_LAST)
          state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY:  if (at_last) state_nxt = STOP;
      STOP:    if (at_s2) state_nxt = DELIVER;
      DELIVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      smp        <= '0;
      shreg      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_fail   <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;

      if (state_nxt == IDLE)  edge_cnt <= '0;
      else if (state == IDLE) edge_cnt <= EW'(1);
      else if (at_last)       edge_cnt <= '0;
      else                    edge_cnt <= edge_cnt + EW'(1);

      if (state == IDLE && start_det) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        par_fail  <= 1'b0;
        bit_cnt   <= '0;
      end

      if (edge_cnt == E_S0) smp[0] <= rx_s;
      if (edge_cnt == E_S1) smp[1] <= rx_s;

      if (state == DATA && at_s2)
        shreg <= {vote, shreg[DATA_SIZE-1:1]};
      if (state == DATA && at_last)
        bit_cnt <= bit_cnt + BW'(1);

      if (state == PARITY && at_s2 &&
          vote != (^shreg ^ par_typ_q))
        par_fail <= 1'b1;

      // strobes are registered so they line up with the DELIVER cycle
      if (state == STOP && at_s2) begin
        Stp_Err <= !vote;
        Par_Err <= par_fail;
        if (vote && !par_fail) begin
          Data_Valid <= 1'b1;
          P_DATA     <= shreg;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx:
// bit-exact TX driver plus an event-queue reference model.
module tb_uart_rx;

  localparam int DS = 8;
  localparam int P  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_in = 1'b1;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic [DS-1:0] p_data;
  logic          data_valid, par_err, stp_err;

  uart_rx #(
    .DATA_SIZE(DS),
    .PRESCALE (P)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .RX_IN     (rx_in),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .P_DATA    (p_data),
    .Data_Valid(data_valid),
    .Par_Err   (par_err),
    .Stp_Err   (stp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic          dv;
    logic          pe;
    logic          se;
    logic [DS-1:0] data;
  } ev_t;

  ev_t           exp_q[$];
  ev_t           ev_mon;
  logic [DS-1:0] exp_pdata = '0;
  int            checks = 0;
  int            fails = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d",
               tag, got, exp, cyc);
    end
  endtask

  // each frame's outcome is queued with its expected cycle
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_pdata = '0;
    end else if (data_valid | par_err | stp_err) begin
      if (exp_q.size() == 0) begin
        chk("spurious", {data_valid, par_err, stp_err}, 0);
      end else begin
        ev_mon = exp_q.pop_front();
        chk("ev_cycle", cyc, ev_mon.cyc);
        chk("ev_flags", {data_valid, par_err, stp_err},
            {ev_mon.dv, ev_mon.pe, ev_mon.se});
        if (ev_mon.dv) exp_pdata = ev_mon.data;
        chk("p_data", p_data, exp_pdata);
      end
    end else begin
      chk("p_data_hold", p_data, exp_pdata);
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("missed_ev", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out", {p_data, data_valid, par_err, stp_err}, 0);
    tick();
  endtask

  task automatic drive_bit(input logic b, input logic spike);
    rx_in = b;
    if (spike) begin
      repeat (P / 2 - 1) tick();
      rx_in = ~b;
      tick();
      rx_in = b;
      repeat (P / 2) tick();
    end else begin
      repeat (P) tick();
    end
  endtask

  task automatic send_frame(input logic [DS-1:0] d,
                            input logic pen,
                            input logic ptyp,
                            input logic bad_par,
                            input logic bad_stop,
                            input logic spikes,
                            input int   abort_at);
    ev_t  e;
    logic pb;
    int   k;
    pb      = ^d ^ ptyp ^ bad_par;
    k       = pen ? DS + 2 : DS + 1;
    par_en  = pen;
    par_typ = ptyp;
    if (abort_at < 0) begin
      e.cyc  = cyc + 2 + k * P + P / 2 + 2;
      e.se   = bad_stop;
      e.pe   = pen && (pb != (^d ^ ptyp));
      e.dv   = !e.se && !e.pe;
      e.data = d;
      exp_q.push_back(e);
    end
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < DS; i++) begin
      if (i == abort_at) begin
        rx_in = d[i];
        repeat (P / 2) tick();
        rx_in = 1'b1;
        do_reset();
        return;
      end
      drive_bit(d[i], spikes);
      if (i == 1) begin
        par_en  = 1'($urandom);
        par_typ = 1'($urandom);
      end
    end
    if (pen) drive_bit(pb, 1'b0);
    drive_bit(!bad_stop, 1'b0);
  endtask

  initial begin
    logic [DS-1:0] d;
    logic          pen, pt, bp, bs, sp;

    do_reset();
    repeat (5) tick();

    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    repeat (10) tick();

    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    repeat (10) tick();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    repeat (10) tick();

    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    repeat (40) tick();
    rx_in = 1'b1;
    repeat (30) tick();

    rx_in = 1'b0;
    repeat (3) tick();
    rx_in = 1'b1;
    repeat (20) tick();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    repeat (10) tick();

    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'hEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    repeat (10) tick();

    send_frame(8'h9A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    repeat (10) tick();
    send_frame(8'h6B, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    repeat (10) tick();

    for (int n = 0; n < 40; n++) begin
      d   = DS'($urandom);
      pen = 1'($urandom);
      pt  = 1'($urandom);
      bp  = ($urandom_range(0, 5) == 0);
      bs  = ($urandom_range(0, 7) == 0);
      sp  = 1'($urandom);
      send_frame(d, pen, pt, bp, bs, sp, -1);
      if (bs) begin
        rx_in = 1'b1;
        repeat (P) tick();
      end
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (40) tick();
    chk("q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
